// File: rtl/rf_serial_seq_if.sv
// Issue, register-file and serial-ALU signals of the sequencer, bundled as one port.
// The slave modport is the sequencer's view; master is the surrounding system.
interface rf_serial_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              flush;
  logic              start;
  logic [ADDR_W-1:0] rs1_sel;
  logic [ADDR_W-1:0] rs2_sel;
  logic [ADDR_W-1:0] rd_sel;
  logic              wb_en;
  logic              ready;
  logic [ADDR_W-1:0] rf_rs1;
  logic [ADDR_W-1:0] rf_rs2;
  logic [DATA_W-1:0] rf_rs1_data;
  logic [DATA_W-1:0] rf_rs2_data;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic              op_a_bit;
  logic              op_b_bit;
  logic              bit_valid;
  logic              bit_first;
  logic              bit_last;
  logic              res_bit;
  logic              done;

  modport slave (
    input  flush, start, rs1_sel, rs2_sel, rd_sel, wb_en,
    input  rf_rs1_data, rf_rs2_data, res_bit,
    output ready, rf_rs1, rf_rs2, rf_rd, rf_wdata, rf_we,
    output op_a_bit, op_b_bit, bit_valid, bit_first, bit_last, done
  );

  modport master (
    output flush, start, rs1_sel, rs2_sel, rd_sel, wb_en,
    output rf_rs1_data, rf_rs2_data, res_bit,
    input  ready, rf_rs1, rf_rs2, rf_rd, rf_wdata, rf_we,
    input  op_a_bit, op_b_bit, bit_valid, bit_first, bit_last, done
  );
endinterface

// File: rtl/rf_serial_seq.sv
// Sequencer between a small parallel register file and a bit-serial ALU: fetch two
// operands, stream them LSB-first, gather the serial result, write it back once.
module rf_serial_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic clk,
  input  logic rst,
  rf_serial_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_WB
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic              wb_en_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] r_q;
  logic [CNT_W-1:0]  cnt_q;

  assign bus.rf_rs1   = rs1_q;
  assign bus.rf_rs2   = rs2_q;
  assign bus.rf_rd    = rd_q;
  assign bus.rf_wdata = r_q;

  // Next state and per-state outputs; flush overrides every transition.
  always_comb begin
    state_n       = state;
    bus.ready     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_first = 1'b0;
    bus.bit_last  = 1'b0;
    bus.op_a_bit  = 1'b0;
    bus.op_b_bit  = 1'b0;
    bus.rf_we     = 1'b0;
    bus.done      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_n = S_FETCH;
      end
      S_FETCH: state_n = S_SHIFT;
      S_SHIFT: begin
        bus.bit_valid = 1'b1;
        bus.bit_first = (cnt_q == '0);
        bus.bit_last  = (cnt_q == CNT_LAST);
        bus.op_a_bit  = a_q[0];
        bus.op_b_bit  = b_q[0];
        if (cnt_q == CNT_LAST) state_n = S_WB;
      end
      S_WB: begin
        bus.done  = ~bus.flush;
        bus.rf_we = wb_en_q & ~bus.flush;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (bus.flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wb_en_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            rs1_q   <= bus.rs1_sel;
            rs2_q   <= bus.rs2_sel;
            rd_q    <= bus.rd_sel;
            wb_en_q <= bus.wb_en;
          end
        end
        // Operands captured here; read addresses were latched one edge earlier.
        S_FETCH: begin
          a_q   <= bus.rf_rs1_data;
          b_q   <= bus.rf_rs2_data;
          cnt_q <= '0;
        end
        // Result enters at the MSB so bit 0 lands in R[0] after DATA_W shifts.
        S_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= {bus.res_bit, r_q[DATA_W-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_serial_seq.sv
// Bench for rf_serial_seq: a behavioural register file plus serial XOR/ADD ALU drive the
// sequencer; expected results come from whole-word arithmetic on the register contents.
module tb_rf_serial_seq;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_serial_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  rf_serial_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] rf [1<<AW];
  logic alu_add = 1'b0;
  logic carry   = 1'b0;
  logic cin;
  int   errors  = 0;
  int   checks  = 0;

  assign bus.rf_rs1_data = rf[bus.rf_rs1];
  assign bus.rf_rs2_data = rf[bus.rf_rs2];
  assign cin             = bus.bit_first ? 1'b0 : carry;
  assign bus.res_bit     = bus.op_a_bit ^ bus.op_b_bit ^ (alu_add & cin);

  always @(posedge clk)
    if (bus.bit_valid)
      carry <= (bus.op_a_bit & bus.op_b_bit) | (cin & (bus.op_a_bit ^ bus.op_b_bit));

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete op issued from idle; cycle n is the cycle after accept edge n.
  task automatic test_op(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic [AW-1:0] d, input logic wb, input string tag,
                         output logic [DW-1:0] seen);
    logic [DW-1:0] ea, eb, er;
    ea   = rf[s1];
    eb   = rf[s2];
    er   = alu_add ? ea + eb : ea ^ eb;
    seen = '0;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before got=%b want=1", tag, bus.ready);
    end
    bus.start = 1'b1; bus.rs1_sel = s1; bus.rs2_sel = s2; bus.rd_sel = d; bus.wb_en = wb;
    tick();
    bus.start   = 1'b0;
    bus.rs1_sel = AW'($urandom);
    bus.rs2_sel = AW'($urandom);
    bus.rd_sel  = AW'($urandom);
    bus.wb_en   = 1'($urandom);
    for (int cyc = 1; cyc <= DW + 3; cyc++) begin
      if (cyc == 1) begin
        checks++;
        if ({bus.rf_rs1, bus.rf_rs2, bus.ready} !== {s1, s2, 1'b0}) begin
          errors++;
          $display("FAIL %s fetch_addr got=%h/%h rdy=%b want=%h/%h rdy=0",
                   tag, bus.rf_rs1, bus.rf_rs2, bus.ready, s1, s2);
        end
      end
      checks++;
      if (cyc >= 2 && cyc <= DW + 1) begin
        if ({bus.bit_valid, bus.bit_first, bus.bit_last, bus.op_a_bit, bus.op_b_bit} !==
            {1'b1, 1'(cyc == 2), 1'(cyc == DW + 1), ea[cyc-2], eb[cyc-2]}) begin
          errors++;
          $display("FAIL %s serial cyc=%0d got vfl_ab=%b want=%b", tag, cyc,
                   {bus.bit_valid, bus.bit_first, bus.bit_last, bus.op_a_bit, bus.op_b_bit},
                   {1'b1, 1'(cyc == 2), 1'(cyc == DW + 1), ea[cyc-2], eb[cyc-2]});
        end
      end else begin
        if ({bus.bit_valid, bus.bit_first, bus.bit_last, bus.op_a_bit, bus.op_b_bit} !== 5'b0) begin
          errors++;
          $display("FAIL %s serial_idle cyc=%0d got=%b want=00000", tag, cyc,
                   {bus.bit_valid, bus.bit_first, bus.bit_last, bus.op_a_bit, bus.op_b_bit});
        end
      end
      checks++;
      if ({bus.done, bus.rf_we} !== ((cyc == DW + 2) ? {1'b1, wb} : 2'b00)) begin
        errors++;
        $display("FAIL %s done_we cyc=%0d got=%b want=%b", tag, cyc, {bus.done, bus.rf_we},
                 (cyc == DW + 2) ? {1'b1, wb} : 2'b00);
      end
      if (cyc == DW + 2) begin
        checks++;
        if (bus.rf_rd !== d || bus.rf_wdata !== er) begin
          errors++;
          $display("FAIL %s writeback got rd=%0d data=%h want rd=%0d data=%h",
                   tag, bus.rf_rd, bus.rf_wdata, d, er);
        end
        seen = bus.rf_wdata;
        if (bus.rf_we === 1'b1) rf[bus.rf_rd] = bus.rf_wdata;
      end
      if (cyc == DW + 3) begin
        checks++;
        if (bus.ready !== 1'b1) begin
          errors++;
          $display("FAIL %s ready_after got=%b want=1", tag, bus.ready);
        end
      end
      if (cyc < DW + 3) tick();
    end
  endtask

  task automatic test_xor_wb;
    logic [DW-1:0] seen;
    alu_add = 1'b0;
    rf[1] = 16'h00A5; rf[2] = 16'h0F0F; rf[3] = 16'h0000;
    test_op(3'd1, 3'd2, 3'd3, 1'b1, "xor_wb", seen);
    checks++;
    if (seen !== 16'h0FAA || rf[3] !== 16'h0FAA) begin
      errors++;
      $display("FAIL xor_wb result got=%h rf3=%h want=0faa", seen, rf[3]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.ready, bus.rf_we, bus.done, bus.bit_valid} !== 4'b1000 ||
        bus.rf_wdata !== '0 || bus.rf_rd !== '0 || bus.rf_rs1 !== '0 || bus.rf_rs2 !== '0) begin
      errors++;
      $display("FAIL reset got rdy/we/done/vld=%b wdata=%h rd=%0d rs=%0d/%0d want 1000 0 0 0/0",
               {bus.ready, bus.rf_we, bus.done, bus.bit_valid}, bus.rf_wdata, bus.rf_rd,
               bus.rf_rs1, bus.rf_rs2);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_no_wb;
    logic [DW-1:0] seen;
    rf[3] = 16'h1234;
    test_op(3'd1, 3'd2, 3'd3, 1'b0, "no_wb", seen);
    checks++;
    if (rf[3] !== 16'h1234) begin
      errors++;
      $display("FAIL no_wb rf3 got=%h want=1234", rf[3]);
    end
  endtask

  task automatic test_start_held;
    logic [DW-1:0] exp1, exp2;
    rf[5] = DW'($urandom); rf[6] = DW'($urandom);
    exp1 = rf[1] ^ rf[2];
    exp2 = rf[5] ^ rf[6];
    bus.start = 1'b1; bus.rs1_sel = 3'd1; bus.rs2_sel = 3'd2; bus.rd_sel = 3'd4; bus.wb_en = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 2 * DW + 6; cyc++) begin
      if (cyc == 5) begin
        bus.rs1_sel = 3'd5; bus.rs2_sel = 3'd6; bus.rd_sel = 3'd7;
      end
      checks++;
      if (bus.ready !== 1'((cyc == DW + 3) || (cyc == 2 * DW + 6))) begin
        errors++;
        $display("FAIL start_held ready cyc=%0d got=%b", cyc, bus.ready);
      end
      if (cyc == DW + 2 || cyc == 2 * DW + 5) begin
        checks++;
        if ({bus.done, bus.rf_we} !== 2'b11 ||
            bus.rf_rd !== ((cyc == DW + 2) ? 3'd4 : 3'd7) ||
            bus.rf_wdata !== ((cyc == DW + 2) ? exp1 : exp2)) begin
          errors++;
          $display("FAIL start_held wb cyc=%0d got done_we=%b rd=%0d data=%h want 11 rd=%0d data=%h",
                   cyc, {bus.done, bus.rf_we}, bus.rf_rd, bus.rf_wdata,
                   (cyc == DW + 2) ? 3'd4 : 3'd7, (cyc == DW + 2) ? exp1 : exp2);
        end
        if (bus.rf_we === 1'b1) rf[bus.rf_rd] = bus.rf_wdata;
      end
      if (cyc == DW + 4) begin
        checks++;
        if (bus.rf_rs1 !== 3'd5 || bus.rf_rs2 !== 3'd6) begin
          errors++;
          $display("FAIL start_held second_fetch got=%0d/%0d want=5/6", bus.rf_rs1, bus.rf_rs2);
        end
        bus.start = 1'b0;
      end
      if (cyc < 2 * DW + 6) tick();
    end
  endtask

  task automatic test_flush;
    logic [DW-1:0] old;
    old = rf[3];
    bus.start = 1'b1; bus.rs1_sel = 3'd1; bus.rs2_sel = 3'd2; bus.rd_sel = 3'd3; bus.wb_en = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= DW + 6; cyc++) begin
      if (cyc == 10) bus.flush = 1'b1;
      if (cyc == 11) begin
        bus.flush = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.bit_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush idle got rdy=%b vld=%b want rdy=1 vld=0", bus.ready, bus.bit_valid);
        end
      end
      checks++;
      if ({bus.done, bus.rf_we} !== 2'b00) begin
        errors++;
        $display("FAIL flush done_we cyc=%0d got=%b want=00", cyc, {bus.done, bus.rf_we});
      end
      if (bus.rf_we === 1'b1) rf[bus.rf_rd] = bus.rf_wdata;
      tick();
    end
    checks++;
    if (rf[3] !== old) begin
      errors++;
      $display("FAIL flush rf3 got=%h want=%h", rf[3], old);
    end
    bus.flush = 1'b1; bus.start = 1'b1;
    tick();
    bus.flush = 1'b0; bus.start = 1'b0;
    checks++;
    if (bus.ready !== 1'b1 || bus.rf_rs1 === 1'bx) begin
      errors++;
      $display("FAIL flush_start_idle ready got=%b want=1", bus.ready);
    end
    tick();
    checks++;
    if (bus.ready !== 1'b1 || bus.bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_idle later got rdy=%b vld=%b want 1/0", bus.ready, bus.bit_valid);
    end
  endtask

  task automatic test_reset_midop;
    logic [DW-1:0] seen, old;
    old = rf[5];
    bus.start = 1'b1; bus.rs1_sel = 3'd1; bus.rs2_sel = 3'd2; bus.rd_sel = 3'd5; bus.wb_en = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      if (cyc == 12) rst = 1'b0;
      checks++;
      if ({bus.done, bus.rf_we} !== 2'b00) begin
        errors++;
        $display("FAIL rst_midop done_we cyc=%0d got=%b want=00", cyc, {bus.done, bus.rf_we});
      end
      if (cyc == 13) begin
        checks++;
        if (bus.ready !== 1'b1 || bus.bit_valid !== 1'b0 || bus.rf_wdata !== '0 ||
            bus.rf_rd !== '0 || bus.rf_rs1 !== '0) begin
          errors++;
          $display("FAIL rst_midop state got rdy=%b vld=%b wdata=%h rd=%0d rs1=%0d",
                   bus.ready, bus.bit_valid, bus.rf_wdata, bus.rf_rd, bus.rf_rs1);
        end
      end
      if (cyc < 13) tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if (rf[5] !== old) begin
      errors++;
      $display("FAIL rst_midop rf5 got=%h want=%h", rf[5], old);
    end
    test_op(3'd1, 3'd2, 3'd3, 1'b1, "after_rst", seen);
    checks++;
    if (seen !== 16'h0FAA) begin
      errors++;
      $display("FAIL after_rst result got=%h want=0faa", seen);
    end
  endtask

  task automatic test_random_add;
    logic [DW-1:0] seen;
    alu_add = 1'b1;
    for (int i = 0; i < (1 << AW); i++) rf[i] = DW'($urandom);
    rf[0] = 16'hFFFF; rf[7] = 16'h0001;
    test_op(3'd0, 3'd7, 3'd6, 1'b1, "add_wrap", seen);
    for (int n = 0; n < 12; n++)
      test_op(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
              AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand_add", seen);
    alu_add = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0; bus.start = 1'b0; bus.wb_en = 1'b0;
    bus.rs1_sel = '0; bus.rs2_sel = '0; bus.rd_sel = '0;
    for (int i = 0; i < (1 << AW); i++) rf[i] = DW'($urandom);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    test_xor_wb();
    test_reset();
    test_no_wb();
    test_start_held();
    test_flush();
    test_reset_midop();
    test_random_add();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
